// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the IF stage. It is a direct-mapped table that
// combines a branch history table (2-bit saturating counters) with a branch
// target buffer (tag + target). The fetch PC is looked up combinationally. The
// resolved branch or jump in ID trains the table on the rising edge.
//
// Ports
//   clk_i          : clock; all state updates on the rising edge
//   rst_i          : asynchronous, active-low reset
//   pc_i           : fetch PC (IF)
//   pred_taken_o   : predict taken for pc_i
//   pred_target_o  : predicted target (valid when pred_taken_o = 1, else 0)
//   upd_valid_i    : a resolved control-transfer instruction is in ID
//   upd_pc_i       : PC of the resolved instruction
//   upd_taken_i    : actual outcome
//   upd_target_i   : actual target
//   flush_i        : invalidate all entries (wins over a same-edge update)
//
// Optional build macro BRANCH_PRED_STATS_EN adds:
//   upd_mispredict_i : the resolving instruction was mispredicted
//   stat_lookups_o   : saturating count of edges with upd_valid_i = 1
//   stat_mispred_o   : saturating count of edges with upd_valid_i & upd_mispredict_i
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            flush_i
`ifdef BRANCH_PRED_STATS_EN
    ,
    input  logic            upd_mispredict_i,
    output logic [31:0]     stat_lookups_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Flattened read views of the per-entry storage, indexed by lookup/update.
    logic             valid_all  [ENTRIES];
    logic [1:0]       ctr_all    [ENTRIES];
    logic [TAG_W-1:0] tag_all    [ENTRIES];
    logic [XLEN-1:0]  target_all [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (IF): pure combinational read, zero latency, no bypass of a
    // same-edge update.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx        = pc_i[IDX_W+1:2];
    assign lk_tag        = pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit        = valid_all[lk_idx] && (tag_all[lk_idx] == lk_tag);
    assign pred_taken_o  = lk_hit & ctr_all[lk_idx][1];
    assign pred_target_o = lk_hit ? target_all[lk_idx] : '0;

    // ------------------------------------------------------------------
    // Update (ID): the hit status is evaluated against the table contents
    // at upd_pc_i before the edge.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_go;

    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_all[upd_idx] && (tag_all[upd_idx] == upd_tag);
    // A flush on the same edge drops the update entirely.
    assign upd_go  = upd_valid_i & ~flush_i;

    // Byte-offset and high PC bits do not take part in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i, upd_pc_i};

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [1:0]       ctr_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [XLEN-1:0]  target_reg;
            logic             valid_next;
            logic [1:0]       ctr_next;
            logic             sel;
            logic             wr_data;

            assign sel = upd_go && (upd_idx == IDX_W'(gi));

            always_comb begin
                valid_next = valid_reg;
                ctr_next   = ctr_reg;
                if (flush_i) begin
                    // Counters intentionally survive a flush.
                    valid_next = 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (upd_taken_i) begin
                            ctr_next = (ctr_reg == 2'b11) ? 2'b11 : ctr_reg + 2'b01;
                        end else begin
                            ctr_next = (ctr_reg == 2'b00) ? 2'b00 : ctr_reg - 2'b01;
                        end
                    end else if (upd_taken_i) begin
                        // Allocate (evicting any previous occupant) as weakly taken.
                        valid_next = 1'b1;
                        ctr_next   = 2'b10;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b01;
                end else begin
                    valid_reg <= valid_next;
                    ctr_reg   <= ctr_next;
                end
            end

            // Tag and target have no reset, but a write is still blocked while
            // reset is held so an entry is never left half-written.
            assign wr_data = sel & upd_taken_i & rst_i;

            always_ff @(posedge clk_i) begin
                if (wr_data) begin
                    tag_reg    <= upd_tag;
                    target_reg <= upd_target_i;
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign ctr_all[gi]    = ctr_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
        end
    endgenerate

`ifdef BRANCH_PRED_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters. They are cleared only by reset, not
    // by flush.
    // ------------------------------------------------------------------
    logic [31:0] stat_lookups_reg;
    logic [31:0] stat_mispred_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_lookups_reg <= '0;
            stat_mispred_reg <= '0;
        end else begin
            if (upd_valid_i && (stat_lookups_reg != 32'hFFFF_FFFF)) begin
                stat_lookups_reg <= stat_lookups_reg + 32'd1;
            end
            if (upd_valid_i && upd_mispredict_i && (stat_mispred_reg != 32'hFFFF_FFFF)) begin
                stat_mispred_reg <= stat_mispred_reg + 32'd1;
            end
        end
    end

    assign stat_lookups_o = stat_lookups_reg;
    assign stat_mispred_o = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. Every lookup pushes its expected
// prediction (from a small behavioural table model, or a fixed value) into a
// scoreboard queue. The entry is popped and compared once the combinational
// output has settled. The statistics section is built only when
// BRANCH_PRED_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [XLEN-1:0] pc_i = 32'h0000_0040;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid_i = 1'b0;
    logic [XLEN-1:0] upd_pc_i = '0;
    logic            upd_taken_i = 1'b0;
    logic [XLEN-1:0] upd_target_i = '0;
    logic            flush_i = 1'b0;
`ifdef BRANCH_PRED_STATS_EN
    logic            upd_mispredict_i = 1'b0;
    logic [31:0]     stat_lookups_o;
    logic [31:0]     stat_mispred_o;
    logic [31:0]     m_lookups;
    logic [31:0]     m_mispred;
`endif

    branch_predictor #(
        .XLEN   (XLEN),
        .ENTRIES(ENTRIES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .flush_i      (flush_i)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .upd_mispredict_i(upd_mispredict_i),
        .stat_lookups_o  (stat_lookups_o),
        .stat_mispred_o  (stat_mispred_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string           name;
        logic            taken;
        logic [XLEN-1:0] target;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural reference table.
    logic            m_valid [ENTRIES];
    int              m_tag   [ENTRIES];
    int              m_ctr   [ENTRIES];
    logic [XLEN-1:0] m_tgt   [ENTRIES];

    function automatic int f_idx(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int f_tag(input logic [XLEN-1:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    task automatic check_value(input string tag, input logic [XLEN-1:0] got,
                               input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
`ifdef BRANCH_PRED_STATS_EN
        m_lookups = '0;
        m_mispred = '0;
`endif
    endtask

    // Apply the currently driven update/flush to the model (called just after the edge).
    task automatic model_apply();
        int  i;
        bit  hit;
`ifdef BRANCH_PRED_STATS_EN
        if (upd_valid_i) begin
            if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
            if (upd_mispredict_i && m_mispred != 32'hFFFF_FFFF) m_mispred++;
        end
`endif
        if (flush_i) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (upd_valid_i) begin
            i   = f_idx(upd_pc_i);
            hit = m_valid[i] && (m_tag[i] == f_tag(upd_pc_i));
            if (hit) begin
                if (upd_taken_i) begin
                    if (m_ctr[i] < 3) m_ctr[i]++;
                    m_tgt[i] = upd_target_i;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (upd_taken_i) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = f_tag(upd_pc_i);
                m_ctr[i]   = 2;
                m_tgt[i]   = upd_target_i;
            end
        end
    endtask

    task automatic push_model(input string name, input logic [XLEN-1:0] pc);
        exp_t e;
        int   i;
        bit   hit;
        i        = f_idx(pc);
        hit      = m_valid[i] && (m_tag[i] == f_tag(pc));
        e.name   = name;
        e.taken  = hit && (m_ctr[i] >= 2);
        e.target = hit ? m_tgt[i] : '0;
        sb_q.push_back(e);
    endtask

    task automatic push_const(input string name, input logic taken, input logic [XLEN-1:0] tgt);
        exp_t e;
        e.name   = name;
        e.taken  = taken;
        e.target = tgt;
        sb_q.push_back(e);
    endtask

    // Drive pc, let the combinational lookup settle, pop and compare.
    task automatic sample(input logic [XLEN-1:0] pc);
        exp_t e;
        pc_i = pc;
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check_value({e.name, ".taken"}, {{(XLEN-1){1'b0}}, pred_taken_o}, {{(XLEN-1){1'b0}}, e.taken});
            check_value({e.name, ".target"}, pred_target_o, e.target);
            $display("lookup %-14s pc=%h taken=%0b target=%h", e.name, pc, pred_taken_o, pred_target_o);
        end
    endtask

    task automatic look_model(input string name, input logic [XLEN-1:0] pc);
        push_model(name, pc);
        sample(pc);
    endtask

    task automatic look_const(input string name, input logic [XLEN-1:0] pc,
                              input logic taken, input logic [XLEN-1:0] tgt);
        push_const(name, taken, tgt);
        sample(pc);
    endtask

    task automatic drive_upd(input logic [XLEN-1:0] pc, input logic taken,
                             input logic [XLEN-1:0] tgt, input logic flush, input logic mis);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        flush_i      = flush;
`ifdef BRANCH_PRED_STATS_EN
        upd_mispredict_i = mis;
`else
        if (mis) begin end
`endif
    endtask

    // Idle the update port with junk payload to show it is ignored.
    task automatic idle_upd();
        upd_valid_i  = 1'b0;
        flush_i      = 1'b0;
        upd_pc_i     = $urandom;
        upd_taken_i  = 1'($urandom);
        upd_target_i = $urandom;
`ifdef BRANCH_PRED_STATS_EN
        upd_mispredict_i = 1'($urandom);
`endif
    endtask

    task automatic commit();
        @(posedge clk_i);
        #1;
        model_apply();
        $display("update pc=%h valid=%0b taken=%0b target=%h flush=%0b",
                 upd_pc_i, upd_valid_i, upd_taken_i, upd_target_i, flush_i);
        idle_upd();
    endtask

    task automatic update(input logic [XLEN-1:0] pc, input logic taken,
                          input logic [XLEN-1:0] tgt);
        drive_upd(pc, taken, tgt, 1'b0, 1'b0);
        commit();
    endtask

    initial begin
        model_reset();

        // Reset state while reset is held, then after release.
        look_const("rst_held", 32'h40, 1'b0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        look_const("rst_release", 32'h40, 1'b0, 32'h0);

        // Allocation and counter walk.
        update(32'h40, 1'b1, 32'h100);
        look_const("alloc", 32'h40, 1'b1, 32'h100);
        update(32'h40, 1'b0, 32'h0);
        look_const("ctr01", 32'h40, 1'b0, 32'h100);
        update(32'h40, 1'b0, 32'h0);
        look_const("ctr00", 32'h40, 1'b0, 32'h100);
        update(32'h40, 1'b1, 32'h100);
        look_model("ctr01b", 32'h40);
        update(32'h40, 1'b1, 32'h100);
        look_const("ctr10", 32'h40, 1'b1, 32'h100);
        update(32'h40, 1'b1, 32'h100);
        update(32'h40, 1'b1, 32'h100);
        look_model("ctr11_sat", 32'h40);
        // Saturated at 11: one not-taken must still leave it predicting taken.
        update(32'h40, 1'b0, 32'h0);
        look_const("sat_hi", 32'h40, 1'b1, 32'h100);
        // Drive down past zero, then one taken must give 01 (not-taken).
        update(32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b0, 32'h0);
        update(32'h40, 1'b1, 32'h100);
        look_const("sat_lo", 32'h40, 1'b0, 32'h100);

        // Alias: same index, different tag evicts.
        update(32'h140, 1'b1, 32'h200);
        look_const("alias_old", 32'h40, 1'b0, 32'h0);
        look_const("alias_new", 32'h140, 1'b1, 32'h200);

        // Miss and not-taken does not allocate.
        update(32'h44, 1'b0, 32'h0);
        look_const("miss_nt", 32'h44, 1'b0, 32'h0);

        // Index and tag boundaries.
        update(32'hFF, 1'b1, 32'h400);
        look_const("idx_max", 32'hFC, 1'b1, 32'h400);
        look_const("hi_bits", 32'h0001_00FC, 1'b1, 32'h400);
        look_const("tag_msb", 32'h0000_80FC, 1'b0, 32'h0);
        update(32'h0, 1'b1, 32'h404);
        look_const("idx_zero", 32'h3, 1'b1, 32'h404);

        // Flush wins over a same-edge update.
        drive_upd(32'h80, 1'b1, 32'h300, 1'b1, 1'b0);
        commit();
        look_const("flush_40", 32'h40, 1'b0, 32'h0);
        look_const("flush_80", 32'h80, 1'b0, 32'h0);
        look_const("flush_140", 32'h140, 1'b0, 32'h0);
        look_const("flush_fc", 32'hFC, 1'b0, 32'h0);

        // Same-cycle lookup and update: pre-update contents, new value next cycle.
        update(32'h80, 1'b1, 32'h300);
        drive_upd(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        look_const("same_pre", 32'h80, 1'b1, 32'h300);
        commit();
        look_const("same_post", 32'h80, 1'b0, 32'h300);
        drive_upd(32'h84, 1'b1, 32'h600, 1'b0, 1'b0);
        look_const("alloc_pre", 32'h84, 1'b0, 32'h0);
        commit();
        look_const("alloc_post", 32'h84, 1'b1, 32'h600);

        // upd_* ignored when upd_valid_i = 0.
        for (int c = 0; c < 4; c++) begin
            idle_upd();
            commit();
        end
        look_model("idle_84", 32'h84);
        look_model("idle_80", 32'h80);

        // Reset mid-operation with an update in flight.
        drive_upd(32'h84, 1'b1, 32'h700, 1'b0, 1'b0);
        #2 rst_i = 1'b0;
        model_reset();
        look_const("rst_async", 32'h84, 1'b0, 32'h0);
        @(posedge clk_i);
        #1 idle_upd();
        #1 rst_i = 1'b1;
        look_const("rst_drop", 32'h84, 1'b0, 32'h0);
        update(32'h84, 1'b1, 32'h800);
        look_const("post_rst", 32'h84, 1'b1, 32'h800);

`ifdef BRANCH_PRED_STATS_EN
        // Statistics: 5 updates, 2 mispredicted, one carrying a flush.
        rst_i = 1'b0;
        model_reset();
        #1 check_value("stat_rst_look", stat_lookups_o, 32'd0);
        check_value("stat_rst_mis", stat_mispred_o, 32'd0);
        #1 rst_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_upd(32'h40 + 32'(k * 4), 1'b1, 32'h900, (k == 2), (k == 1 || k == 3));
            commit();
        end
        check_value("stat_look5", stat_lookups_o, 32'd5);
        check_value("stat_mis2", stat_mispred_o, 32'd2);
        check_value("stat_look_m", stat_lookups_o, m_lookups);
        update(32'h40, 1'b0, 32'h0);
        check_value("stat_idle_mis", stat_mispred_o, m_mispred);
        drive_upd(32'h44, 1'b1, 32'h0, 1'b0, 1'b1);
        #2 rst_i = 1'b0;
        model_reset();
        #1 check_value("stat_mid_look", stat_lookups_o, 32'd0);
        check_value("stat_mid_mis", stat_mispred_o, 32'd0);
        @(posedge clk_i);
        #1 idle_upd();
        rst_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor; successor to the current static scheme (branch resolved by the register-equality compare in ID, IF_ID flushed when taken).
- Direct-mapped table of 2-bit saturating counters with tag and target (BHT+BTB), looked up combinationally from the fetch PC in IF.
- Trained from ID when the branch/jump resolves.
- Enables predict-taken fetch so a correctly predicted branch costs zero bubbles.

Parameters:
- XLEN, 32, PC and target width.
- ENTRIES, 64, table depth; power of two, at least 2.
- TAG_W, 8, tag bits stored per entry; XLEN-2-IDX_W must be at least TAG_W.
- Derived, not overridable: IDX_W = clog2(ENTRIES).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pc_i  in  XLEN  fetch PC (IF stage).
- pred_taken_o  out  1  predict taken for pc_i.
- pred_target_o  out  XLEN  predicted target; valid when pred_taken_o=1.
- upd_valid_i  in  1  resolved control-transfer instruction in ID this cycle.
- upd_pc_i  in  XLEN  PC of the resolved instruction.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual target.
- flush_i  in  1  invalidate all entries.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Per entry: valid (1), tag (TAG_W), ctr (2), target (XLEN).
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = target[idx] when hit, else 0.
- Reset (rst_i=0, asynchronous):
  - All valid bits cleared; all ctr set to 2'b01 (weakly not-taken).
  - Target and tag storage are not reset.
  - pred_taken_o=0 and pred_target_o=0 immediately.
- Update (rising edge, upd_valid_i=1), table read at upd_pc_i:
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target_i.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, ctr=2'b10, target = upd_target_i. Evicts any prior occupant.
  - Miss, not taken: no change.
- flush_i=1 at an edge:
  - Clears every valid bit; ctr is untouched.
  - Takes priority over a simultaneous update; that update is dropped.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. No bypass. The new value is visible the cycle after the edge.
- Counter saturation: 3 stays 3 on taken; 0 stays 0 on not-taken. No wrap.
- Reset asserted mid-operation:
  - Any in-flight update is discarded.
  - No partial entry writes.
- X-safety: upd_* inputs are ignored when upd_valid_i=0.

Optional Feature:
- Macro: BRANCH_PRED_STATS_EN.
- Defined:
  - Adds input upd_mispredict_i (1) and outputs stat_lookups_o (32) and stat_mispred_o (32).
  - stat_lookups_o increments on every edge with upd_valid_i=1.
  - stat_mispred_o increments when upd_valid_i & upd_mispredict_i.
  - Both saturate at 32'hFFFFFFFF, reset to 0, and are unaffected by flush_i.
- Undefined:
  - Ports and counters are absent.
  - Table behaviour is identical in both builds.

Test Plan:
1. Release reset with pc_i=32'h0000_0040 -> pred_taken_o=0, pred_target_o=0.
2. Update upd_pc_i=32'h40, taken, target 32'h100. Next cycle pc_i=32'h40 -> pred_taken_o=1, pred_target_o=32'h100.
3. Then two not-taken updates to 32'h40 -> counter goes 10 to 01 to 00, pred_taken_o=0. Three taken updates -> 11, and a fourth taken update keeps it at 11.
4. Alias test (ENTRIES=64): allocate 32'h40, then a taken update at 32'h140 (same idx, different tag) -> lookup of 32'h40 misses, 32'h140 hits with the new target.
5. Same-edge flush_i=1 and a taken update to 32'h80 -> the following lookups of 32'h40 and 32'h80 both give pred_taken_o=0.
6. With BRANCH_PRED_STATS_EN: 5 updates, 2 of them with upd_mispredict_i=1 -> stat_lookups_o=5, stat_mispred_o=2. Asserting rst_i=0 mid-sequence -> both read 0 immediately.
